demux4_latched_router: RTL and testbench

//  1-to-4 routing demultiplexer: inverse of the 4:1 selector path.
//  On each strobe it writes a data word into one of four held output channels.
//  The channel comes from sel (manual mode) or from an internal rotating pointer (auto mode).

---
 rtl/demux4_latched_router.sv | 66 ++++++
 tb/tb_demux4_latched_router.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/demux4_latched_router.sv
// 1-to-4 routing demultiplexer: each synchronized rising edge of strobe_in writes din
// into one of four held output channels, chosen by sel or by a rotating auto pointer.
module demux4_latched_router #(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic                 strobe_in,
    input  logic                 auto_mode,
    input  logic [1:0]           sel,
    input  logic [WIDTH-1:0]     din,
    output logic [4*WIDTH-1:0]   dout,
    output logic [3:0]           upd,
    output logic [1:0]           ptr
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [4*WIDTH-1:0]     dout_q, dout_d;
    logic [3:0]             upd_q, upd_d;
    logic [1:0]             ptr_q, ptr_d;
    logic [1:0]             target;
    logic                   strobe_event;

    // Edge history runs regardless of ena, so a strobe already high when ena rises is not an edge.
    assign strobe_event = sync_q[SYNC_STAGES-1] & ~prev_q & ena;
    assign target       = auto_mode ? ptr_q : sel;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        dout_d = dout_q;
        upd_d  = '0;
        ptr_d  = ptr_q;
        if (strobe_event) begin
            dout_d[target*WIDTH +: WIDTH] = din;
            upd_d                         = 4'b0001 << target;
            if (auto_mode) begin
                ptr_d = ptr_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            dout_q <= '0;
            upd_q  <= '0;
            ptr_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], strobe_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            dout_q <= dout_d;
            upd_q  <= upd_d;
            ptr_q  <= ptr_d;
        end
    end

    assign dout = dout_q;
    assign upd  = upd_q;
    assign ptr  = ptr_q;

endmodule

// File: tb/tb_demux4_latched_router.sv
// Randomized scoreboard bench for demux4_latched_router: a channel-array reference model
// predicts each write; a monitor pops predictions whenever upd pulses.
module tb_demux4_latched_router;

    localparam int W = 1;

    typedef struct {
        logic [3:0]   upd;
        logic [4*W-1:0] dout;
        logic [1:0]   ptr;
        int           cyc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           ena = 1'b1;
    logic           strobe_in = 1'b0;
    logic           auto_mode = 1'b0;
    logic [1:0]     sel = 2'd0;
    logic [W-1:0]   din = '0;
    logic [4*W-1:0] dout;
    logic [3:0]     upd;
    logic [1:0]     ptr;

    int   cyc = 0;
    int   n_total = 0;
    int   n_pass = 0;
    int   pulses = 0;
    int   upd_cnt [4];
    logic [3:0] last_upd = '0;

    exp_t         sb_q [$];
    logic [W-1:0] m_ch [4];
    int           m_ptr = 0;

    demux4_latched_router #(.WIDTH(W), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .strobe_in (strobe_in),
        .auto_mode (auto_mode),
        .sel       (sel),
        .din       (din),
        .dout      (dout),
        .upd       (upd),
        .ptr       (ptr)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [4*W-1:0] m_dout();
        logic [4*W-1:0] v;
        for (int k = 0; k < 4; k++) v[k*W +: W] = m_ch[k];
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) m_ch[k] = '0;
        m_ptr = 0;
        sb_q.delete();
    endtask

    // Called on the falling edge where strobe_in is raised; the write is visible 3 rising edges later.
    task automatic model_write(input logic [W-1:0] d, input logic [1:0] s, input logic a);
        int   t;
        exp_t e;
        t = a ? m_ptr : int'(s);
        m_ch[t] = d;
        if (a) m_ptr = (m_ptr + 1) % 4;
        e.upd  = 4'(1 << t);
        e.dout = m_dout();
        e.ptr  = 2'(m_ptr);
        e.cyc  = cyc + 3;
        sb_q.push_back(e);
    endtask

    task automatic do_write(input logic [W-1:0] d, input logic [1:0] s, input logic a, input logic en);
        @(negedge clk);
        din = d; sel = s; auto_mode = a; ena = en; strobe_in = 1'b1;
        if (en) model_write(d, s, a);
        repeat (3) @(negedge clk);
        strobe_in = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Monitor: every upd pulse must match the oldest prediction; an overdue prediction is a miss.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (upd != 4'd0) begin
                pulses++;
                last_upd = upd;
                for (int k = 0; k < 4; k++) upd_cnt[k] += int'(upd[k]);
                if (sb_q.size() == 0) begin
                    check("unexpected_upd", 32'(upd), 32'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("upd", 32'(upd), 32'(e.upd));
                    check("dout", 32'(dout), 32'(e.dout));
                    check("ptr", 32'(ptr), 32'(e.ptr));
                    check("latency_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
                e = sb_q.pop_front();
                check("missing_upd", 32'(upd), 32'(e.upd));
            end
        end
    end

    initial begin
        int p0;
        int c0 [4];
        logic [W-1:0] dv [8];
        for (int k = 0; k < 4; k++) upd_cnt[k] = 0;
        model_reset();

        #1;
        check("reset_dout", 32'(dout), 32'd0);
        check("reset_upd", 32'(upd), 32'd0);
        check("reset_ptr", 32'(ptr), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Manual routing
        do_write(1'b1, 2'd0, 1'b0, 1'b1);
        do_write(1'b0, 2'd1, 1'b0, 1'b1);
        do_write(1'b1, 2'd2, 1'b0, 1'b1);
        do_write(1'b1, 2'd3, 1'b0, 1'b1);
        check("manual_final_dout", 32'(dout), 32'b1101);

        // Asynchronous reset mid-run, with strobe already high when released
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        strobe_in = 1'b1; auto_mode = 1'b0; sel = 2'd1; din = 1'b1;
        #1;
        check("async_reset_dout", 32'(dout), 32'd0);
        check("async_reset_upd", 32'(upd), 32'd0);
        check("async_reset_ptr", 32'(ptr), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_write(1'b1, 2'd1, 1'b0);
        repeat (3) @(negedge clk);
        strobe_in = 1'b0;
        repeat (2) @(negedge clk);

        // Auto rotation with wrap
        do_write(1'b1, 2'd3, 1'b1, 1'b1);
        do_write(1'b1, 2'd3, 1'b1, 1'b1);
        do_write(1'b0, 2'd3, 1'b1, 1'b1);
        do_write(1'b1, 2'd3, 1'b1, 1'b1);
        check("auto_wrap_ptr", 32'(ptr), 32'd0);
        do_write(1'b0, 2'd3, 1'b1, 1'b1);
        check("auto_final_dout", 32'(dout), 32'b1010);
        check("auto_final_ptr", 32'(ptr), 32'd1);

        // Held strobe gives exactly one write
        p0 = pulses;
        @(negedge clk);
        auto_mode = 1'b0; sel = 2'd2; din = 1'b1; strobe_in = 1'b1;
        model_write(1'b1, 2'd2, 1'b0);
        repeat (20) @(negedge clk);
        strobe_in = 1'b0;
        repeat (3) @(negedge clk);
        check("held_strobe_pulses", 32'(pulses - p0), 32'd1);

        // ena low: strobes ignored
        ena = 1'b0; din = 1'b0; sel = 2'd0; auto_mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); strobe_in = 1'b1;
            repeat (2) @(negedge clk); strobe_in = 1'b0;
            repeat (2) @(negedge clk);
        end
        check("ena_low_dout", 32'(dout), 32'(m_dout()));
        check("ena_low_ptr", 32'(ptr), 32'(m_ptr));

        // ena raised while strobe already high
        p0 = pulses;
        @(negedge clk); strobe_in = 1'b1;
        repeat (4) @(negedge clk); ena = 1'b1;
        repeat (6) @(negedge clk); strobe_in = 1'b0;
        repeat (3) @(negedge clk);
        check("ena_rise_no_event", 32'(pulses - p0), 32'd0);

        // Mode switch retains ptr
        reset_dut();
        do_write(1'b1, 2'd0, 1'b1, 1'b1);
        do_write(1'b0, 2'd0, 1'b1, 1'b1);
        check("mode_ptr_after_auto", 32'(ptr), 32'd2);
        do_write(1'b1, 2'd0, 1'b0, 1'b1);
        check("mode_ptr_after_manual", 32'(ptr), 32'd2);
        do_write(1'b1, 2'd0, 1'b1, 1'b1);
        check("mode_resume_upd", 32'(last_upd), 32'b0100);

        // Back-to-back strobes at the synchronizer limit
        p0 = pulses;
        for (int k = 0; k < 4; k++) c0[k] = upd_cnt[k];
        for (int i = 0; i < 8; i++) dv[i] = W'($urandom_range(0, 1));
        auto_mode = 1'b1;
        @(negedge clk); din = dv[0];
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); strobe_in = 1'b1;
            model_write(dv[i], 2'd0, 1'b1);
            @(negedge clk); strobe_in = 1'b0; din = dv[i];
        end
        repeat (5) @(negedge clk);
        check("sync_limit_pulses", 32'(pulses - p0), 32'd8);
        for (int k = 0; k < 4; k++) check("sync_limit_per_channel", 32'(upd_cnt[k] - c0[k]), 32'd2);

        // Randomized mix of modes, selects, data and enable
        for (int i = 0; i < 40; i++) begin
            do_write(W'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        end
        ena = 1'b1;
        check("random_final_dout", 32'(dout), 32'(m_dout()));
        check("random_final_ptr", 32'(ptr), 32'(m_ptr));

        repeat (8) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
